// File: rtl/sd_spi_pkg.sv
// Shared constants and types for the SD SPI responder.
//   IDLE_BYTE_DEF : MISO byte sent when the tx buffer is empty
//   CMD_START     : top two bits of the first byte of an SD command
//   CMD_LEN       : number of bytes in an SD command frame
//   fr_state_e    : command framer states
package sd_spi_pkg;

    localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;
    localparam logic [1:0] CMD_START     = 2'b01;
    localparam logic [2:0] CMD_LEN       = 3'd6;

    typedef enum logic {
        FR_IDLE,
        FR_COLLECT
    } fr_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous SPI pin.
//   clock_i : system clock
//   reset_i : synchronous active-high reset
//   d_i     : asynchronous pin
//   level_o : synchronized level
//   rise_o  : one-cycle pulse on a synchronized 0->1 transition
//   fall_o  : one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
    parameter int unsigned SYNC_STG = 2,
    parameter logic        RST_VAL  = 1'b0
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STG-1:0] sync_q;
    logic                prev_q;

    // RST_VAL matches the idle level of the pin so that leaving reset
    // with the pin idle produces no spurious edge.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_q <= {SYNC_STG{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], d_i};
            prev_q <= sync_q[SYNC_STG-1];
        end
    end

    assign level_o = sync_q[SYNC_STG-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/sd_spi_responder.sv
// SPI mode-0 responder emulating the card side of an SD SPI link.
// Assembles MOSI bytes, drives MISO from a one-byte tx buffer and frames
// 6-byte SD commands (start 01b, index, 32-bit arg, CRC7, end bit).
//   clock_i     : system clock (25 MHz)
//   reset_i     : synchronous active-high reset
//   spi_cs_i    : chip select, active low
//   spi_sclk_i  : serial clock from master, idle low
//   spi_mosi_i  : data from master
//   spi_miso_o  : data to master
//   miso_oe_o   : MISO drive enable, high while CS is low
//   rx_data_o   : last received byte
//   rx_valid_o  : one-cycle pulse, rx_data_o updated
//   tx_data_i   : next byte to transmit
//   tx_load_i   : write tx_data_i into the tx buffer
//   tx_ready_o  : tx buffer empty
//   cmd_valid_o : one-cycle pulse, complete command framed
//   cmd_index_o : command index
//   cmd_arg_o   : command argument, first argument byte is the MSB
//   cmd_crc_o   : CRC7 field of the last byte
//   cmd_err_o   : one-cycle pulse, frame ended with end bit 0
//
// Framer states:
//   state      | meaning
//   FR_IDLE    | waiting for a byte matching 01xxxxxx
//   FR_COLLECT | collecting argument, CRC and end-bit bytes
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter logic [7:0]  IDLE_BYTE = IDLE_BYTE_DEF,
    parameter int unsigned SYNC_STG  = 2
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        spi_cs_i,
    input  logic        spi_sclk_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    output logic        miso_oe_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_load_i,
    output logic        tx_ready_o,
    output logic        cmd_valid_o,
    output logic [5:0]  cmd_index_o,
    output logic [31:0] cmd_arg_o,
    output logic [6:0]  cmd_crc_o,
    output logic        cmd_err_o
);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_cs (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     (spi_cs_i),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_sclk (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     (spi_sclk_i),
        .level_o (sclk_level),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_mosi (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .d_i     (spi_mosi_i),
        .level_o (mosi_level),
        .rise_o  (mosi_rise),
        .fall_o  (mosi_fall)
    );

    assign unused_sync = ^{sclk_level, mosi_rise, mosi_fall};

    // ------------------------------------------------------------------
    // Byte engine
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q,  rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_buf_q,   tx_buf_d;
    logic       tx_full_q,  tx_full_d;
    logic       miso_oe_q,  miso_oe_d;
    logic       reload;
    logic [7:0] reload_byte;

    // A load in the reload cycle wins over the buffer so the freshest
    // byte goes out without a detour through the buffer.
    always_comb begin
        reload_byte = IDLE_BYTE;
        if (tx_load_i) begin
            reload_byte = tx_data_i;
        end else if (tx_full_q) begin
            reload_byte = tx_buf_q;
        end
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_full_d  = tx_full_q;
        miso_oe_d  = miso_oe_q;
        reload     = 1'b0;

        if (tx_load_i) begin
            tx_buf_d  = tx_data_i;
            tx_full_d = 1'b1;
        end

        if (cs_fall) begin
            bit_cnt_d = 3'd0;
            miso_oe_d = 1'b1;
            reload    = 1'b1;
        end else if (cs_rise) begin
            // The shifter MSB is the MISO pin, so parking it at all ones
            // returns MISO high while deselected.
            bit_cnt_d  = 3'd0;
            miso_oe_d  = 1'b0;
            tx_shift_d = 8'hFF;
        end else if (!cs_level) begin
            if (sclk_rise) begin
                rx_shift_d = {rx_shift_q[5:0], mosi_level};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_data_d  = {rx_shift_q, mosi_level};
                    rx_valid_d = 1'b1;
                end
            end else if (sclk_fall) begin
                if (bit_cnt_q != 3'd0) begin
                    tx_shift_d = {tx_shift_q[6:0], 1'b1};
                end else begin
                    reload = 1'b1;
                end
            end
        end

        if (reload) begin
            tx_shift_d = reload_byte;
            tx_full_d  = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 7'd0;
            rx_data_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            tx_shift_q <= 8'hFF;
            tx_buf_q   <= 8'd0;
            tx_full_q  <= 1'b0;
            miso_oe_q  <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            miso_oe_q  <= miso_oe_d;
        end
    end

    assign spi_miso_o = tx_shift_q[7];
    assign miso_oe_o  = miso_oe_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_ready_o = ~tx_full_q;

    // ------------------------------------------------------------------
    // Command framer
    // ------------------------------------------------------------------
    fr_state_e   fr_state_q, fr_state_d;
    logic [2:0]  fr_cnt_q,   fr_cnt_d;
    logic [5:0]  idx_q,      idx_d;
    logic [31:0] arg_q,      arg_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        cmd_err_q,   cmd_err_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q,   cmd_arg_d;
    logic [6:0]  cmd_crc_q,   cmd_crc_d;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fr_state_q  <= FR_IDLE;
            fr_cnt_q    <= 3'd0;
            idx_q       <= 6'd0;
            arg_q       <= 32'd0;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_index_q <= 6'd0;
            cmd_arg_q   <= 32'd0;
            cmd_crc_q   <= 7'd0;
        end else begin
            fr_state_q  <= fr_state_d;
            fr_cnt_q    <= fr_cnt_d;
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            cmd_crc_q   <= cmd_crc_d;
        end
    end

    always_comb begin
        fr_state_d = fr_state_q;
        fr_cnt_d   = fr_cnt_q;
        if (cs_rise) begin
            fr_state_d = FR_IDLE;
            fr_cnt_d   = 3'd0;
        end else if (rx_valid_q) begin
            case (fr_state_q)
                FR_IDLE: begin
                    if (rx_data_q[7:6] == CMD_START) begin
                        fr_state_d = FR_COLLECT;
                        fr_cnt_d   = 3'd1;
                    end
                end
                FR_COLLECT: begin
                    if (fr_cnt_q == CMD_LEN - 3'd1) begin
                        fr_state_d = FR_IDLE;
                        fr_cnt_d   = 3'd0;
                    end else begin
                        fr_cnt_d = fr_cnt_q + 3'd1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        idx_d       = idx_q;
        arg_d       = arg_q;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        cmd_crc_d   = cmd_crc_q;
        cmd_valid_d = 1'b0;
        cmd_err_d   = 1'b0;
        if (!cs_rise && rx_valid_q) begin
            case (fr_state_q)
                FR_IDLE: begin
                    if (rx_data_q[7:6] == CMD_START) begin
                        idx_d = rx_data_q[5:0];
                    end
                end
                FR_COLLECT: begin
                    if (fr_cnt_q == CMD_LEN - 3'd1) begin
                        if (rx_data_q[0]) begin
                            cmd_valid_d = 1'b1;
                            cmd_index_d = idx_q;
                            cmd_arg_d   = arg_q;
                            cmd_crc_d   = rx_data_q[7:1];
                        end else begin
                            cmd_err_d = 1'b1;
                        end
                    end else begin
                        arg_d = {arg_q[23:0], rx_data_q};
                    end
                end
            endcase
        end
    end

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_err_o   = cmd_err_q;
    assign cmd_index_o = cmd_index_q;
    assign cmd_arg_o   = cmd_arg_q;
    assign cmd_crc_o   = cmd_crc_q;

endmodule
